usart_rx_buffered: RTL

USART_RX_BUFFERED -- requirements
Module: usart_rx_buffered

---
 rtl/usart_rx_buffered.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/usart_rx_buffered.sv
// rtl/usart_rx_buffered.sv - 8N1 serial receiver with a first-word-fall-through receive FIFO
// Mid-bit sampling from a latched bit period; the byte is pushed on a high stop sample.
module usart_rx_buffered #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] clocks_per_bit,
   input  logic        rx_pin,
   output logic [7:0]  data_out,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        framing_error,
   output logic        overrun,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t      state_q;
   logic        rx_meta_q, rx_sync_q;
   logic [11:0] cpb_q, cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic        framing_error_q, overrun_q;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   logic stop_sample, push, pop, full, accept;

   assign stop_sample = (state_q == STOP) && (cnt_q == cpb_q - 12'd1);
   assign push        = stop_sample && rx_sync_q;
   assign data_valid  = (count_q != '0);
   assign pop         = data_valid && data_ready;
   assign full        = (count_q == (AW+1)'(FIFO_DEPTH));
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign accept      = push && (!full || pop);

   assign data_out      = data_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign framing_error = framing_error_q;
   assign overrun       = overrun_q;
   assign busy          = (state_q != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         rx_meta_q       <= 1'b1;
         rx_sync_q       <= 1'b1;
         cpb_q           <= 12'd0;
         cnt_q           <= 12'd0;
         bit_cnt_q       <= 3'd0;
         shift_q         <= 8'h00;
         framing_error_q <= 1'b0;
      end else begin
         rx_meta_q       <= rx_pin;
         rx_sync_q       <= rx_meta_q;
         framing_error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_sync_q) begin
                  state_q   <= START;
                  cpb_q     <= clocks_per_bit;
                  cnt_q     <= 12'd0;
                  bit_cnt_q <= 3'd0;
               end
            end
            START: begin
               if (cnt_q == (cpb_q >> 1) - 12'd1) begin
                  cnt_q   <= 12'd0;
                  state_q <= rx_sync_q ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            DATA: begin
               if (cnt_q == cpb_q - 12'd1) begin
                  cnt_q     <= 12'd0;
                  shift_q   <= {rx_sync_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            STOP: begin
               if (stop_sample) begin
                  cnt_q <= 12'd0;
                  if (rx_sync_q) begin
                     state_q <= IDLE;
                  end else begin
                     framing_error_q <= 1'b1;
                     state_q         <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 12'd1;
               end
            end
            WAIT_HIGH: begin
               if (rx_sync_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && full && !pop;
         if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && accept) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

endmodule
